// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory end of the core's DMEM bus. It accepts one word-aligned load or store
// at a time under a req/ready handshake. It waits WAIT_CYCLES states before it
// responds. Stores honour per-lane byte enables. Load data is returned through
// a register that holds its value until the next successful load. A misaligned
// request gets a one-cycle error response and never touches storage.
//
// Parameters
//   DATA_W      : data word width (fixed at 32, four byte lanes)
//   ADDR_W      : byte-address width; storage holds 2^(ADDR_W-2) words
//   WAIT_CYCLES : wait states between accept and response (0..15)
//
// Ports
//   CLK     in   clock; all state changes on its rising edge
//   RESET   in   asynchronous, active-high reset
//   req     in   request valid, looked at only while idle
//   d_rw    in   1 = store, 0 = load
//   daddr   in   byte address; word index is daddr[ADDR_W-1:2]
//   ddata_w in   store data
//   be      in   store byte enables; be[i] covers ddata_w[8i+7:8i]
//   ddata_r out  registered load data
//   ready   out  one-cycle completion pulse
//   err     out  one-cycle error flag, only ever high together with ready
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] ddata_w,
  input  logic [3:0]        be,
  output logic [DATA_W-1:0] ddata_r,
  output logic              ready,
  output logic              err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [3:0]        cnt;

  // Request captured at the accept edge. Inputs are ignored after that edge.
  logic              rw_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              misaligned;
  logic              commit;
  logic              c_rw;
  logic [IDX_W-1:0]  c_idx;
  logic [DATA_W-1:0] c_wdata;
  logic [3:0]        c_be;

  assign accept     = (state == S_IDLE) && req;
  assign misaligned = (daddr[1:0] != 2'b00);

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (misaligned)            state_nxt = S_ERR;
          else if (WAIT_CYCLES == 0) state_nxt = S_RESP;
          else                       state_nxt = S_WAIT;
        end
      end
      S_WAIT:  if (cnt == 4'd1) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The access commits on the edge that enters RESP. With zero wait states,
  // that edge is also the accept edge. The latched copy does not exist yet,
  // so the live inputs are used.
  assign commit  = (state_nxt == S_RESP);
  assign c_rw    = (state == S_IDLE) ? d_rw                 : rw_q;
  assign c_idx   = (state == S_IDLE) ? daddr[ADDR_W-1:2]    : idx_q;
  assign c_wdata = (state == S_IDLE) ? ddata_w              : wdata_q;
  assign c_be    = (state == S_IDLE) ? be                   : be_q;

  // NOTE: storage has no reset. Its contents survive RESET and are undefined
  // at power-up. Gating with RESET ensures that an edge seen while reset is
  // held cannot commit a store.
  always_ff @(posedge CLK) begin
    if (commit && c_rw && !RESET) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rw_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= 4'd0;
      ddata_r <= '0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        rw_q    <= d_rw;
        idx_q   <= daddr[ADDR_W-1:2];
        wdata_q <= ddata_w;
        be_q    <= be;
        cnt     <= (!misaligned && WAIT_CYCLES != 0) ? WAIT_INIT : 4'd0;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end

      if (commit && !c_rw) ddata_r <= mem[c_idx];
    end
  end

  // Both response states last exactly one cycle, so the pulses are decoded
  // straight from the state register.
  assign ready = (state == S_RESP) || (state == S_ERR);
  assign err   = (state == S_ERR);

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the processor's DMEM port, the memory end of the bus on which the core issues `daddr`/`ddata_w`/`d_rw`. It accepts one word-aligned load or store at a time under a req/ready handshake. It inserts a configurable number of wait states, applies byte enables on stores and returns registered read data. Misaligned requests complete with an error response and leave storage untouched.

## Interface
- `DATA_W`, 32: data word width; fixed to 32 with 4 byte lanes.
- `ADDR_W`, 10: byte-address width. Storage is 2^(ADDR_W-2) words.
- `WAIT_CYCLES`, 2: wait states between accept and response; 0 to 15 legal.

- `CLK`  in  1: single clock; all state updates on its rising edge.
- `RESET`  in  1: reset, asynchronous and active-high.
- `req`  in  1: request valid, sampled only in IDLE.
- `d_rw`  in  1: 1 = store, 0 = load.
- `daddr`  in  ADDR_W: byte address. Word index = `daddr[ADDR_W-1:2]`.
- `ddata_w`  in  DATA_W: store data.
- `be`  in  4: store byte enables. `be[i]` writes `ddata_w[8i+7:8i]`.
- `ddata_r`  out  DATA_W: load data, registered.
- `ready`  out  1: one-cycle completion pulse.
- `err`  out  1: one-cycle error flag, only ever high together with `ready`.

## Operation
- FSM states: IDLE, WAIT, RESP, ERR.
- IDLE with `req`=1 at a rising edge (accept):
  - latch `d_rw`, `daddr`, `ddata_w` and `be`;
  - if `daddr[1:0]` != 0, go to ERR;
  - else if `WAIT_CYCLES` = 0, go to RESP;
  - else go to WAIT with counter = `WAIT_CYCLES`.
- WAIT: counter decrements at each edge. The edge at which the counter equals 1 moves the FSM to RESP.
- Edge entering RESP:
  - store: write every byte lane whose latched `be` bit is 1; lanes with `be` = 0 keep their value. `be` = 4'b0000 is a legal no-op store.
  - load: `ddata_r` <= full word at the latched index. `be` is ignored.
- RESP: `ready`=1, `err`=0 for exactly one cycle, then IDLE.
- ERR: `ready`=1, `err`=1 for one cycle, then IDLE.
  - No storage write.
  - `ddata_r` is unchanged.
- `ddata_r` changes only on a successful load. It holds its value through stores, errors and idle cycles.
- Inputs are ignored outside IDLE. Dropping `req` or changing `daddr`/`d_rw`/`ddata_w`/`be` during WAIT/RESP/ERR does not affect the transaction in flight.
- `req` still high in the cycle after RESP/ERR (IDLE) is accepted as a new request.
- Address wrap: none needed. Every word index within `ADDR_W` maps to storage.
- Storage contents are not cleared by `RESET` and are undefined at power-up.

## Timing
- Reset values: state IDLE, `ready`=0, `err`=0, `ddata_r`=0, counter=0.
- `RESET` asserted mid-transaction:
  - return to IDLE immediately (asynchronously);
  - an un-committed store is discarded;
  - no `ready` pulse for the aborted request.
- Accept edge = end of cycle 0. `ready` is high in cycle `WAIT_CYCLES`+1.
- Error latency: `ready`/`err` are high in cycle 1, independent of `WAIT_CYCLES`.
- Minimum request-to-request spacing:
  - `WAIT_CYCLES`+2 cycles for a valid access;
  - 2 cycles for an error.
- `ddata_r` is valid in the `ready` cycle and remains stable afterwards until the next successful load.
- Read-after-write: a load accepted after a store's RESP cycle sees the stored data.

## Test plan
- Reset check: `RESET`=1 then 0 -> `ready`=0, `err`=0, `ddata_r`=0x00000000, FSM idle.
- Store, then load (`WAIT_CYCLES`=2):
  - store 0xDEADBEEF to 0x010 with `be`=4'hF -> `ready` high in cycle 3;
  - load from 0x010 -> `ready` in cycle 3 and `ddata_r`=0xDEADBEEF.
- Byte enables: with word 0x010 = 0xDEADBEEF, store 0x11223344 with `be`=4'b0101 -> a following load returns 0xDE22BE44.
- Misaligned access:
  - load from 0x013 -> `ready`=`err`=1 in cycle 1 and `ddata_r` unchanged;
  - store to 0x022 -> error pulse, and a later aligned load of 0x020 shows the old contents.
- Back-to-back requests with `req` held high:
  - four loads to 0x000, 0x004, 0x008, 0x00C -> four `ready` pulses spaced 4 cycles apart, with the correct data in each pulse cycle;
  - dropping `req` during WAIT -> the transaction still completes.
- Reset mid-store: assert `RESET` during WAIT of a store of 0xCAFEF00D to 0x040 -> no `ready` pulse, and after reset a load of 0x040 returns the prior value.
